// File: rtl/wram_pkg.sv
// Shared definitions for the banked work RAM.
// The effective-bank helper is also used by the HDMA source-address checker.
package wram_pkg;

  localparam int          DEF_BANK_AW   = 12;
  localparam int          DEF_NUM_BANKS = 8;
  localparam int          DEF_DATA_W    = 8;
  localparam logic [15:0] SVBK_ADDR     = 16'hFF70;

  // Bank 0 can never be selected for the upper window; it aliases to bank 1.
  function automatic logic [7:0] eff_bank(input logic cgb_mode, input logic [7:0] svbk);
    return (!cgb_mode || svbk == 8'd0) ? 8'd1 : svbk;
  endfunction

endpackage

// File: rtl/wram_array.sv
// Single-port synchronous RAM with a registered read port.
// Kept separate so a vendor block-RAM primitive can be dropped in.
module wram_array #(
  parameter int AW = 15,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array and its read register are deliberately not reset so the
  // storage maps onto block RAM; consumers qualify dout with their own valid.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wram_banked.sv
// CGB work RAM: fixed bank 0, SVBK-switched upper bank, and a DMA read port
// that shares the single-port array with the CPU (DMA wins contention).
module wram_banked
  import wram_pkg::*;
#(
  parameter int BANK_AW   = DEF_BANK_AW,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cgb_mode,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [BANK_AW:0]  cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_valid,
  input  logic              svbk_en,
  input  logic              svbk_we,
  input  logic [7:0]        svbk_din,
  output logic [7:0]        svbk_dout,
  input  logic              dma_req,
  input  logic [BANK_AW:0]  dma_addr,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_dout,
  output logic              dma_valid
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int PHY_AW = BANK_W + BANK_AW;

  logic [BANK_W-1:0] svbk;
  logic [7:0]        eff_full;
  logic [BANK_W-1:0] eff;
  logic              unused_bits;

  logic              arr_en;
  logic              arr_we;
  logic [PHY_AW-1:0] arr_addr;
  logic [DATA_W-1:0] arr_q;

  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] dma_hold;

  function automatic logic [PHY_AW-1:0] phys_addr(input logic [BANK_AW:0] off,
                                                  input logic [BANK_W-1:0] bank);
    return off[BANK_AW] ? {bank, off[BANK_AW-1:0]}
                        : {{BANK_W{1'b0}}, off[BANK_AW-1:0]};
  endfunction

  // SVBK register; writes are only honoured in CGB mode.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; an access at the same edge sees the old bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      svbk <= '0;
    end else if (svbk_en && svbk_we && cgb_mode) begin
      svbk <= svbk_din[BANK_W-1:0];
    end
  end

  // NOTE: default first so every path assigns all bits and no latch is inferred.
  always_comb begin
    svbk_dout              = 8'hFF;
    svbk_dout[BANK_W-1:0]  = svbk;
  end

  assign eff_full    = eff_bank(cgb_mode, 8'(svbk));
  assign eff         = eff_full[BANK_W-1:0];
  assign unused_bits = ^{svbk_din, eff_full};

  // Fixed-priority arbiter: DMA always wins, a stalled CPU simply retries.
  assign dma_gnt   = dma_req;
  assign cpu_ready = cpu_en & ~dma_req;

  always_comb begin
    arr_en   = dma_req | cpu_en;
    arr_we   = 1'b0;
    arr_addr = phys_addr(cpu_addr, eff);
    if (dma_req) begin
      arr_addr = phys_addr(dma_addr, eff);
    end else begin
      arr_we   = cpu_we;
    end
  end

  wram_array #(
    .AW (PHY_AW),
    .DW (DATA_W)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .din  (cpu_din),
    .dout (arr_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_valid <= 1'b0;
      dma_valid <= 1'b0;
    end else begin
      cpu_valid <= cpu_ready & ~cpu_we;
      dma_valid <= dma_req;
    end
  end

  // The array read register is shared, so each port keeps its own copy of the
  // last data it was handed and shows that whenever it is not being updated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_hold <= '0;
      dma_hold <= '0;
    end else begin
      if (cpu_valid) cpu_hold <= arr_q;
      if (dma_valid) dma_hold <= arr_q;
    end
  end

  assign cpu_dout = cpu_valid ? arr_q : cpu_hold;
  assign dma_dout = dma_valid ? arr_q : dma_hold;

endmodule

// File: tb/tb_wram_banked.sv
// Directed bench for wram_banked: a table of CPU accesses with SVBK changes,
// then hand-written sequences for contention, same-edge SVBK and reset.
module tb_wram_banked;

  logic        clk;
  logic        reset_n;
  logic        cgb_mode;
  logic        cpu_en;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_ready;
  logic [7:0]  cpu_dout;
  logic        cpu_valid;
  logic        svbk_en;
  logic        svbk_we;
  logic [7:0]  svbk_din;
  logic [7:0]  svbk_dout;
  logic        dma_req;
  logic [12:0] dma_addr;
  logic        dma_gnt;
  logic [7:0]  dma_dout;
  logic        dma_valid;

  int n_cmp = 0;
  int n_bad = 0;

  wram_banked #(
    .BANK_AW   (12),
    .NUM_BANKS (8),
    .DATA_W    (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cgb_mode  (cgb_mode),
    .cpu_en    (cpu_en),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_ready (cpu_ready),
    .cpu_dout  (cpu_dout),
    .cpu_valid (cpu_valid),
    .svbk_en   (svbk_en),
    .svbk_we   (svbk_we),
    .svbk_din  (svbk_din),
    .svbk_dout (svbk_dout),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_gnt   (dma_gnt),
    .dma_dout  (dma_dout),
    .dma_valid (dma_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        do_svbk;
    logic [7:0]  svbk;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic svbk_write(input logic [7:0] v);
    svbk_en  = 1'b1;
    svbk_we  = 1'b1;
    svbk_din = v;
    tick();
    svbk_en  = 1'b0;
    svbk_we  = 1'b0;
  endtask

  task automatic cpu_access(input string name, input logic we, input logic [12:0] a,
                            input logic [7:0] d, input logic [7:0] exp);
    cpu_en   = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    #1;
    check({name, "/ready"}, 32'(cpu_ready), 32'd1);
    tick();
    cpu_en = 1'b0;
    cpu_we = 1'b0;
    check({name, "/valid"}, 32'(cpu_valid), 32'(!we));
    if (!we) check({name, "/data"}, 32'(cpu_dout), 32'(exp));
  endtask

  initial begin
    vecs = '{
      '{"b0_wr",      1'b0, 8'd0, 1'b1, 13'h0234, 8'h5A, 8'h00},
      '{"wr_a5",      1'b0, 8'd0, 1'b1, 13'h1000, 8'hA5, 8'h00},
      '{"rd_a5",      1'b0, 8'd0, 1'b0, 13'h1000, 8'h00, 8'hA5},
      '{"b2_wr",      1'b1, 8'd2, 1'b1, 13'h1234, 8'h22, 8'h00},
      '{"b3_wr",      1'b1, 8'd3, 1'b1, 13'h1234, 8'h33, 8'h00},
      '{"b2_rd",      1'b1, 8'd2, 1'b0, 13'h1234, 8'h00, 8'h22},
      '{"b3_rd",      1'b1, 8'd3, 1'b0, 13'h1234, 8'h00, 8'h33},
      '{"b0_rd",      1'b0, 8'd0, 1'b0, 13'h0234, 8'h00, 8'h5A},
      '{"b1_wr",      1'b1, 8'd1, 1'b1, 13'h1100, 8'h11, 8'h00},
      '{"alias0_rd",  1'b1, 8'd0, 1'b0, 13'h1100, 8'h00, 8'h11},
      '{"b7_top_wr",  1'b1, 8'd7, 1'b1, 13'h1FFF, 8'h77, 8'h00},
      '{"b7_top_rd",  1'b0, 8'd0, 1'b0, 13'h1FFF, 8'h00, 8'h77},
      '{"b0_top_wr",  1'b0, 8'd0, 1'b1, 13'h0FFF, 8'hEE, 8'h00},
      '{"b0_top_rd",  1'b0, 8'd0, 1'b0, 13'h0FFF, 8'h00, 8'hEE},
      '{"b1_top_wr",  1'b1, 8'd1, 1'b1, 13'h1FFF, 8'h71, 8'h00},
      '{"b7_top_rd2", 1'b1, 8'd7, 1'b0, 13'h1FFF, 8'h00, 8'h77},
      '{"b1_top_rd",  1'b1, 8'd1, 1'b0, 13'h1FFF, 8'h00, 8'h71}
    };

    reset_n  = 1'b0;
    cgb_mode = 1'b1;
    cpu_en   = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_din  = '0;
    svbk_en  = 1'b0;
    svbk_we  = 1'b0;
    svbk_din = '0;
    dma_req  = 1'b0;
    dma_addr = '0;

    // Reset state
    tick();
    tick();
    check("rst/svbk_dout", 32'(svbk_dout), 32'hF8);
    check("rst/cpu_dout",  32'(cpu_dout),  32'h00);
    check("rst/dma_dout",  32'(dma_dout),  32'h00);
    check("rst/cpu_valid", 32'(cpu_valid), 32'd0);
    check("rst/dma_valid", 32'(dma_valid), 32'd0);
    check("rst/dma_gnt",   32'(dma_gnt),   32'd0);
    reset_n = 1'b1;
    tick();

    // Table of CPU accesses (svbk ends at 1)
    foreach (vecs[i]) begin
      if (vecs[i].do_svbk) begin
        svbk_write(vecs[i].svbk);
        check({vecs[i].name, "/svbk_dout"}, 32'(svbk_dout), 32'(8'hF8 | vecs[i].svbk));
      end
      cpu_access(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp);
    end

    // Back-to-back write then read of the same location
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_din = 8'h3C;
    tick();
    cpu_we = 1'b0;
    check("b2b/no_valid_on_wr", 32'(cpu_valid), 32'd0);
    tick();
    cpu_en = 1'b0;
    check("b2b/valid", 32'(cpu_valid), 32'd1);
    check("b2b/data",  32'(cpu_dout),  32'h3C);
    tick();
    check("b2b/valid_drop", 32'(cpu_valid), 32'd0);
    check("b2b/hold",       32'(cpu_dout),  32'h3C);

    // DMA/CPU contention (svbk = 1, bank 1 @1000 holds A5)
    dma_req = 1'b1; dma_addr = 13'h1000;
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0234;
    #1;
    check("arb/dma_gnt",   32'(dma_gnt),   32'd1);
    check("arb/cpu_stall", 32'(cpu_ready), 32'd0);
    tick();
    dma_req = 1'b0;
    #1;
    check("arb/cpu_ready", 32'(cpu_ready), 32'd1);
    check("arb/dma_valid", 32'(dma_valid), 32'd1);
    check("arb/dma_data",  32'(dma_dout),  32'hA5);
    check("arb/cpu_quiet", 32'(cpu_valid), 32'd0);
    tick();
    cpu_en = 1'b0;
    check("arb/cpu_valid", 32'(cpu_valid), 32'd1);
    check("arb/cpu_data",  32'(cpu_dout),  32'h5A);
    check("arb/dma_drop",  32'(dma_valid), 32'd0);
    check("arb/dma_hold",  32'(dma_dout),  32'hA5);

    // SVBK write on the same edge as a read uses the old bank
    svbk_write(8'd2);
    cpu_access("sw/wr_b2", 1'b1, 13'h1000, 8'hB2, 8'h00);
    svbk_write(8'd3);
    cpu_access("sw/wr_b3", 1'b1, 13'h1000, 8'hB3, 8'h00);
    svbk_en = 1'b1; svbk_we = 1'b1; svbk_din = 8'd2;
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1000;
    tick();
    svbk_en = 1'b0; svbk_we = 1'b0; cpu_en = 1'b0;
    check("sw/old_bank",  32'(cpu_dout),  32'hB3);
    check("sw/svbk_dout", 32'(svbk_dout), 32'hFA);
    cpu_access("sw/new_bank", 1'b0, 13'h1000, 8'h00, 8'hB2);

    // Reset asserted while a read request is pending
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0234;
    #3;
    reset_n = 1'b0;
    #1;
    check("rstmid/svbk_dout", 32'(svbk_dout), 32'hF8);
    check("rstmid/cpu_dout",  32'(cpu_dout),  32'h00);
    check("rstmid/dma_dout",  32'(dma_dout),  32'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rstmid/no_valid_in", 32'(cpu_valid), 32'd0);
    end
    cpu_en  = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rstmid/no_valid_out", 32'(cpu_valid), 32'd0);
    end

    // DMG mode: SVBK ignored, upper window fixed to bank 1; contents preserved
    cgb_mode = 1'b0;
    svbk_write(8'd5);
    check("dmg/svbk_ignored", 32'(svbk_dout), 32'hF8);
    cpu_access("dmg/rd_1100", 1'b0, 13'h1100, 8'h00, 8'h11);
    cpu_access("dmg/rd_1000", 1'b0, 13'h1000, 8'h00, 8'hA5);

    cgb_mode = 1'b1;
    svbk_write(8'd3);
    check("cgb/svbk_dout", 32'(svbk_dout), 32'hFB);
    cpu_access("keep/b3_1000", 1'b0, 13'h1000, 8'h00, 8'hB3);
    cpu_access("keep/b0_0234", 1'b0, 13'h0234, 8'h00, 8'h5A);

    cgb_mode = 1'b0;
    #1;
    check("dmg/svbk_retained", 32'(svbk_dout), 32'hFB);
    cpu_access("dmg/bank1_again", 1'b0, 13'h1000, 8'h00, 8'hA5);
    dma_req = 1'b1; dma_addr = 13'h1FFF;
    tick();
    dma_req = 1'b0;
    check("dmg/dma_valid", 32'(dma_valid), 32'd1);
    check("dmg/dma_data",  32'(dma_dout),  32'h71);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wram_banked.md
# wram_banked

Parametrised, banked work-RAM for CGB-mode operation. Splits the CPU WRAM window into a fixed bank 0 and a switchable upper bank selected by an internal SVBK register. Adds a second read-only port for OAM/HDMA DMA engines, arbitrated onto a single-port memory array. Sits behind the bus decoder at C000–DFFF (echo space folded upstream), with the SVBK register decoded at FF70.

## Interface
Parameters:
- BANK_AW, 12: address width of one bank (4 KiB).
- NUM_BANKS, 8: total banks, power of two ≥ 2; BANK_W = $clog2(NUM_BANKS).
- DATA_W, 8: data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cgb_mode  in  1  1 = banking enabled; 0 = DMG behaviour (upper window fixed to bank 1).
- cpu_en  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  BANK_AW+1  window offset; MSB 0 = bank 0, MSB 1 = switchable bank.
- cpu_din  in  DATA_W  write data.
- cpu_ready  out  1  request accepted this cycle (combinational).
- cpu_dout  out  DATA_W  read data, valid with cpu_valid.
- cpu_valid  out  1  one-cycle pulse, read data available.
- svbk_en  in  1  SVBK register access.
- svbk_we  in  1  SVBK write strobe.
- svbk_din  in  8  SVBK write data.
- svbk_dout  out  8  SVBK read data (combinational).
- dma_req  in  1  DMA read request.
- dma_addr  in  BANK_AW+1  DMA window offset, same mapping as CPU.
- dma_gnt  out  1  DMA request accepted this cycle (combinational).
- dma_dout  out  DATA_W  DMA read data.
- dma_valid  out  1  one-cycle pulse, DMA data available.

## Operation
- SVBK register: BANK_W bits, reset 0. Written from svbk_din[BANK_W-1:0] when svbk_en & svbk_we & cgb_mode; ignored when cgb_mode = 0. svbk_dout = unused upper bits forced to 1, low BANK_W bits = register.
- Effective bank: eff = (cgb_mode == 0 || svbk == 0) ? 1 : svbk.
- Physical address: addr MSB 0 → {0, addr[BANK_AW-1:0]}; MSB 1 → {eff, addr[BANK_AW-1:0]}. Array depth NUM_BANKS × 2^BANK_AW. Array contents are not reset.
- Arbiter: one array access per cycle. DMA has priority. dma_gnt = dma_req. cpu_ready = cpu_en & ~dma_req. A stalled CPU holds en/we/addr/din stable until cpu_ready.
- Granted CPU write: array updated, no cpu_valid. Granted CPU read: cpu_dout/cpu_valid next cycle. Granted DMA: dma_dout/dma_valid next cycle.
- cpu_dout and dma_dout hold their last value when not updated; neither output is ever driven Z.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream): svbk = 0, cpu_dout = 0, dma_dout = 0, cpu_valid = 0, dma_valid = 0. An access in flight at reset is dropped; no valid pulse follows.
- Read latency: 1 cycle from the accepting edge to valid.
- Back-to-back: one accepted access per cycle, sustained; a write at cycle N is visible to a read accepted at N+1.
- SVBK write at the same edge as a CPU/DMA access: the access uses the old bank; the new bank applies from the next cycle.
- cgb_mode change takes effect combinationally on the next accepted access; the svbk value is retained.
- Address wrap: none; offsets are exact-width, so the top offset of the window maps to the last byte of the selected bank.

## Structure
- Shared package wram_pkg: default BANK_AW/NUM_BANKS, SVBK_ADDR = 16'hFF70, function for effective-bank computation (reused by the HDMA source-address checker).
- One sub-module: wram_array (single-port synchronous RAM, DATA_W × depth, registered read), so the FPGA block-RAM primitive can be swapped. Arbiter, SVBK register and address mapping stay in wram_banked.

## Test plan
- Reset, cgb_mode = 1: svbk_dout = 8'hF8, all outputs 0; write 8'hA5 to offset 13'h1000, read back → 8'hA5 with cpu_valid one cycle after acceptance.
- Bank isolation: SVBK = 2, write 8'h22 @ 13'h1234; SVBK = 3, write 8'h33 @ 13'h1234; SVBK = 2, read → 8'h22; bank-0 offset 13'h0234 is unaffected.
- SVBK = 0 aliases bank 1: write 8'h11 with SVBK = 1, read with SVBK = 0 → 8'h11. With cgb_mode = 0, an SVBK write of 5 is ignored (svbk_dout stays 8'hF8) and the upper window is bank 1.
- Contention: dma_req and a CPU read in the same cycle → dma_gnt = 1, cpu_ready = 0; the CPU read is accepted the next cycle; dma_valid and cpu_valid pulse on consecutive cycles with correct data.
- SVBK write at the same edge as a CPU read of 13'h1000 → data comes from the old bank.
- reset_n asserted mid-read → cpu_valid never pulses; svbk returns to 0; array contents are preserved after release.
